dec_stage: RTL and testbench
============================

# dec_stage

Instruction-decode stage of the processor datapath; sits directly downstream of the instruction-fetch stage and consumes its 32-bit instruction word. It holds the instruction register, the 32×32 register file with write-back selection and same-cycle bypass, and the immediate-extension unit. It presents operands A, B and the extended immediate to the execute stage.

## Interface
- DATA_W, 32, datapath and instruction width
- REG_N, 32, number of architectural registers; register 0 reads as zero
- REG_AW, 5, register address width (log2 REG_N)

- Clk  in  1  system clock, rising-edge active
- Reset  in  1  asynchronous, active-high; clears instruction register and all registers
- Instr  in  32  instruction word from fetch stage
- Instr_LdEn  in  1  load Instr into instruction register (IR) on next rising edge
- RF_WrEn  in  1  register-file write enable
- RF_WrData_sel  in  1  write-back source: 0 = ALU_out, 1 = MEM_out
- RF_B_sel  in  1  port-B read address: 0 = IR[15:11] (rt), 1 = IR[20:16] (rd)
- ImmExt  in  2  immediate mode (see Operation)
- ALU_out  in  32  ALU result for write-back
- MEM_out  in  32  data-memory read data for write-back
- Immed  out  32  extended immediate
- RF_A  out  32  operand A = reg[IR[25:21]]
- RF_B  out  32  operand B = reg[selected address]
- IR_q  out  32  current instruction register contents (to control unit)

## Operation
- Fields of IR: opcode [31:26], rs [25:21], rd [20:16], rt [15:11], imm16 [15:0].
- IR: on posedge, if Instr_LdEn then IR <= Instr, else hold.
- Write: on posedge, if RF_WrEn and IR[20:16] != 0, reg[IR[20:16]] <= WrData; WrData = RF_WrData_sel ? MEM_out : ALU_out. Write address is always rd of the current IR.
- Writes to register 0 are discarded; reg[0] reads 0 always.
- Reads combinational from IR fields and register array.
- Bypass: if RF_WrEn and write address != 0 and equals a read address, that port outputs WrData in the same cycle (write-through).
- ImmExt: 00 zero-extend imm16; 01 sign-extend imm16; 10 imm16 << 16, low half zero; 11 sign-extend imm16 then << 2.
- Immed, RF_A, RF_B all combinational from IR and array; no internal FSM beyond IR and array state.

## Timing
- Reset asserted: IR = 0, all reg = 0 immediately (asynchronous); hence IR_q = 0, RF_A = RF_B = Immed = 0 during and after reset until first load.
- Reset mid-write: reset wins; register cleared, write lost. Release takes effect on next edge only.
- Instr → IR_q: 1 clock (registered). IR → RF_A/RF_B/Immed: combinational, same cycle.
- Write → visible in array: 1 clock; visible at RF_A/RF_B in same cycle via bypass.
- Simultaneous Instr_LdEn and RF_WrEn: write uses rd of old IR (pre-edge), IR updates on the same edge.
- RF_A and RF_B same address: both receive identical value, including bypass.
- Instr_LdEn = 0: IR and all outputs stable except via writes.

## Structure
- Shared package dec_pkg: field bit positions (OPC_HI/LO, RS_HI/LO, RD_HI/LO, RT_HI/LO, IMM_HI/LO), ImmExt encodings IMM_ZERO=2'b00, IMM_SIGN=2'b01, IMM_LUI=2'b10, IMM_BR=2'b11, REG_N, REG_AW.
- One sub-module: register_file (two async read ports, one sync write port, async reset, reg0 hardwired, bypass). IR, write-back mux and extender stay in dec_stage.

## Test plan
- Reset: assert Reset mid-cycle with reg[5]=0x1234 → RF_A/RF_B/Immed/IR_q = 0 immediately; reg[5] reads 0 after release.
- Write/read: load IR with rd=3, ALU_out=0xDEADBEEF, RF_WrEn=1, sel=0 → next IR with rs=3 gives RF_A=0xDEADBEEF; sel=1 with MEM_out=0x00C0FFEE stores 0x00C0FFEE.
- Register 0: write 0xFFFFFFFF with rd=0 → RF_A with rs=0 remains 0x00000000.
- Bypass: IR rs=rd=7, RF_WrEn=1, ALU_out=0x55AA55AA → RF_A=0x55AA55AA in same cycle before the edge.
- Immediate: imm16=0x8001 → ImmExt 00: 0x00008001; 01: 0xFFFF8001; 10: 0x80010000; 11: 0xFFFE0004.
- RF_B_sel: rd=4 (reg=0x44), rt=9 (reg=0x99) → sel 0 gives 0x99, sel 1 gives 0x44; Instr_LdEn=0 holds IR across 3 edges with Instr changing.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the instruction-decode stage: widths, IR field
// positions and immediate-extension mode encodings.
// Pure definitions; no logic.
package dec_pkg;

   localparam int DATA_W = 32;
   localparam int REG_N  = 32;
   localparam int REG_AW = 5;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [REG_AW-1:0] raddr_t;

   // Instruction-register field positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RD_HI  = 20;
   localparam int RD_LO  = 16;
   localparam int RT_HI  = 15;
   localparam int RT_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Immediate-extension modes
   localparam logic [1:0] IMM_ZERO = 2'b00;
   localparam logic [1:0] IMM_SIGN = 2'b01;
   localparam logic [1:0] IMM_LUI  = 2'b10;
   localparam logic [1:0] IMM_BR   = 2'b11;

endpackage

// File: rtl/dec_if.sv
// Decode-stage bus: instruction/control/write-back inputs and operand outputs.
// master = upstream driver (fetch/control/bench), slave = dec_stage.
// No flow control; all signals are sampled or produced every cycle.
interface dec_if;
   import dec_pkg::*;

   word_t      Instr;
   logic       Instr_LdEn;
   logic       RF_WrEn;
   logic       RF_WrData_sel;
   logic       RF_B_sel;
   logic [1:0] ImmExt;
   word_t      ALU_out;
   word_t      MEM_out;
   word_t      Immed;
   word_t      RF_A;
   word_t      RF_B;
   word_t      IR_q;

   modport master (
      output Instr, Instr_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt,
             ALU_out, MEM_out,
      input  Immed, RF_A, RF_B, IR_q
   );

   modport slave (
      input  Instr, Instr_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt,
             ALU_out, MEM_out,
      output Immed, RF_A, RF_B, IR_q
   );

endinterface

// File: rtl/dec_stage_register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Latency: write visible in array after 1 clock, at read ports same cycle (bypass).
// No backpressure. Ports: clk_i, rst_i, wr_en_i/wr_addr_i/wr_data_i,
// ra_addr_i/ra_data_o, rb_addr_i/rb_data_o. Register 0 always reads zero.
module register_file
   import dec_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   wr_en_i,
   input  raddr_t wr_addr_i,
   input  word_t  wr_data_i,
   input  raddr_t ra_addr_i,
   input  raddr_t rb_addr_i,
   output word_t  ra_data_o,
   output word_t  rb_data_o
);

   word_t regs_q [REG_N];
   logic  wr_live;

   // A write to register 0 is a no-op both in the array and on the bypass path.
   assign wr_live = wr_en_i && (wr_addr_i != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_live) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Write-through: a read of the address being written returns the new data.
   always_comb begin
      ra_data_o = '0;
      if (ra_addr_i != '0) begin
         ra_data_o = (wr_live && (wr_addr_i == ra_addr_i)) ? wr_data_i : regs_q[ra_addr_i];
      end
   end

   always_comb begin
      rb_data_o = '0;
      if (rb_addr_i != '0) begin
         rb_data_o = (wr_live && (wr_addr_i == rb_addr_i)) ? wr_data_i : regs_q[rb_addr_i];
      end
   end

endmodule

// File: rtl/dec_stage.sv
// Instruction-decode stage: instruction register, register file with write-back
// select and bypass, immediate extender. Latency: Instr->IR_q 1 clock; IR->operands
// combinational. No backpressure. Ports: Clk, Reset (async active-high), bus (dec_if.slave).
module dec_stage
   import dec_pkg::*;
(
   input logic  Clk,
   input logic  Reset,
   dec_if.slave bus
);

   word_t  ir_q;
   word_t  ir_d;
   word_t  wr_data;
   word_t  immed;
   word_t  rf_a;
   word_t  rf_b;
   raddr_t rb_addr;
   logic [IMM_HI-IMM_LO:0] imm16;

   // Instruction register
   assign ir_d = bus.Instr_LdEn ? bus.Instr : ir_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ir_q <= '0;
      end else begin
         ir_q <= ir_d;
      end
   end

   // Write-back source select; the write always targets rd of the IR currently held,
   // so a simultaneous IR load still writes to the outgoing instruction's rd.
   assign wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
   assign rb_addr = bus.RF_B_sel ? ir_q[RD_HI:RD_LO] : ir_q[RT_HI:RT_LO];

   register_file u_rf (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .wr_en_i   (bus.RF_WrEn),
      .wr_addr_i (ir_q[RD_HI:RD_LO]),
      .wr_data_i (wr_data),
      .ra_addr_i (ir_q[RS_HI:RS_LO]),
      .rb_addr_i (rb_addr),
      .ra_data_o (rf_a),
      .rb_data_o (rf_b)
   );

   // Immediate extender
   assign imm16 = ir_q[IMM_HI:IMM_LO];

   always_comb begin
      immed = '0;
      case (bus.ImmExt)
         IMM_ZERO: immed = {16'b0, imm16};
         IMM_SIGN: immed = {{16{imm16[15]}}, imm16};
         IMM_LUI:  immed = {imm16, 16'b0};
         IMM_BR:   immed = {{14{imm16[15]}}, imm16, 2'b00};
         default:  immed = '0;
      endcase
   end

   assign bus.IR_q  = ir_q;
   assign bus.RF_A  = rf_a;
   assign bus.RF_B  = rf_b;
   assign bus.Immed = immed;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed scenarios with literal expectations followed by
// randomized traffic, all outputs compared every falling edge against a
// behavioural register-file/IR model.
module tb_dec_stage;
   import dec_pkg::*;

   logic Clk;
   logic Reset;

   dec_if bus ();

   dec_stage dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_rf [32];
   logic [31:0] m_ir;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rd,
                                      input logic [15:0] lo);
      return {6'b000010, rs, rd, lo};
   endfunction

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] m_wdata();
      return bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (bus.RF_WrEn && a == m_ir[20:16]) return m_wdata();
      return m_rf[a];
   endfunction

   function automatic logic [31:0] m_imm();
      int u;
      int s;
      u = int'({16'd0, m_ir[15:0]});
      s = (u >= 32768) ? u - 65536 : u;
      case (bus.ImmExt)
         2'd0:    return 32'(u);
         2'd1:    return 32'(s);
         2'd2:    return 32'(u * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_ir <= 32'd0;
         foreach (m_rf[i]) m_rf[i] <= 32'd0;
      end else begin
         if (bus.RF_WrEn && m_ir[20:16] != 5'd0) m_rf[m_ir[20:16]] <= m_wdata();
         if (bus.Instr_LdEn) m_ir <= bus.Instr;
      end
   end

   // Compare process: every falling edge
   always @(negedge Clk) begin
      chk("ir_q",  bus.IR_q,  m_ir);
      chk("rf_a",  bus.RF_A,  m_read(m_ir[25:21]));
      chk("rf_b",  bus.RF_B,  m_read(bus.RF_B_sel ? m_ir[20:16] : m_ir[15:11]));
      chk("immed", bus.Immed, m_imm());
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic [31:0] ins, input logic ld, input logic we,
                      input logic sel, input logic [31:0] alu, input logic [31:0] mem);
      bus.Instr         = ins;
      bus.Instr_LdEn    = ld;
      bus.RF_WrEn       = we;
      bus.RF_WrData_sel = sel;
      bus.ALU_out       = alu;
      bus.MEM_out       = mem;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      @(negedge Clk);
      #1;
   endtask

   logic [31:0] imm_exp [4];
   logic [31:0] held;
   logic [31:0] ins;

   initial begin
      imm_exp[0] = 32'h0000_8001;
      imm_exp[1] = 32'hFFFF_8001;
      imm_exp[2] = 32'h8001_0000;
      imm_exp[3] = 32'hFFFE_0004;

      Reset = 1'b1;
      bus.RF_B_sel = 1'b0;
      bus.ImmExt   = 2'b00;
      drv(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("reset_ir",    bus.IR_q,  32'd0);
      chk("reset_rf_a",  bus.RF_A,  32'd0);
      chk("reset_immed", bus.Immed, 32'd0);
      @(posedge Clk);
      #3 Reset = 1'b0;
      step();

      // Write/read via ALU then MEM write-back
      drv(mk(5'd0, 5'd3, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(mk(5'd3, 5'd0, 16'd0), 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0); step();
      drv(mk(5'd3, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("wr_alu", bus.RF_A, 32'hDEADBEEF); step();
      drv(mk(5'd0, 5'd3, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(mk(5'd3, 5'd0, 16'd0), 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h00C0FFEE); step();
      drv(mk(5'd3, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("wr_mem", bus.RF_A, 32'h00C0FFEE); step();

      // Register 0 ignores writes
      drv(mk(5'd0, 5'd0, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(mk(5'd0, 5'd0, 16'd0), 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0);
      settle(); chk("r0_bypass", bus.RF_A, 32'd0); step();
      drv(mk(5'd0, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("r0_stored", bus.RF_A, 32'd0); step();

      // Same-cycle bypass on both ports
      drv(mk(5'd7, 5'd7, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      bus.RF_B_sel = 1'b1;
      drv(mk(5'd7, 5'd7, 16'd0), 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 32'd0);
      settle();
      chk("bypass_a", bus.RF_A, 32'h55AA55AA);
      chk("bypass_b", bus.RF_B, 32'h55AA55AA);
      step();
      drv(mk(5'd7, 5'd7, 16'd0), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("bypass_stored", bus.RF_A, 32'h55AA55AA); step();
      bus.RF_B_sel = 1'b0;

      // Immediate modes
      drv(mk(5'd0, 5'd0, 16'h8001), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int m = 0; m < 4; m++) begin
         bus.ImmExt = 2'(m);
         settle();
         chk($sformatf("imm_mode%0d", m), bus.Immed, imm_exp[m]);
         step();
      end

      // Port-B address select and IR hold
      drv(mk(5'd0, 5'd4, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(mk(5'd0, 5'd9, 16'd0), 1'b1, 1'b1, 1'b0, 32'h44, 32'd0); step();
      held = mk(5'd0, 5'd4, 16'h4800);
      drv(held, 1'b1, 1'b1, 1'b0, 32'h99, 32'd0); step();
      drv($urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      bus.RF_B_sel = 1'b0;
      settle(); chk("bsel_rt", bus.RF_B, 32'h99);
      bus.RF_B_sel = 1'b1;
      #1 chk("bsel_rd", bus.RF_B, 32'h44);
      for (int k = 0; k < 3; k++) begin
         step();
         drv($urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
         settle();
         chk("ir_hold", bus.IR_q, held);
      end
      step();

      // Reset mid-cycle, concurrent with a pending write
      drv(mk(5'd0, 5'd5, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0); step();
      drv(mk(5'd5, 5'd5, 16'd0), 1'b1, 1'b1, 1'b0, 32'h1234, 32'd0); step();
      drv(mk(5'd5, 5'd5, 16'd0), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("pre_reset_r5", bus.RF_A, 32'h1234); step();
      #2;
      drv(mk(5'd5, 5'd5, 16'd0), 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0);
      Reset = 1'b1;
      #1;
      chk("rst_ir",    bus.IR_q,  32'd0);
      chk("rst_rf_a",  bus.RF_A,  32'd0);
      chk("rst_rf_b",  bus.RF_B,  32'd0);
      chk("rst_immed", bus.Immed, 32'd0);
      @(posedge Clk);
      #3;
      Reset = 1'b0;
      drv(mk(5'd5, 5'd0, 16'd0), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      drv(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      settle(); chk("rst_r5_cleared", bus.RF_A, 32'd0); step();

      // Randomized traffic, checked by the compare process
      for (int c = 0; c < 3000; c++) begin
         ins = $urandom;
         if ($urandom_range(0, 1) == 0) ins[20:16] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) ins[25:21] = ins[20:16];
         if ($urandom_range(0, 3) == 0) ins[15:11] = ins[20:16];
         drv(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, $urandom);
         bus.RF_B_sel = 1'($urandom_range(0, 1));
         bus.ImmExt   = 2'($urandom_range(0, 3));
         Reset = ($urandom_range(0, 199) == 0);
         step();
      end
      Reset = 1'b0;
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
